// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream big-endian into 512-bit blocks
// and appends the 0x80 marker, zero fill and 64-bit bit-length.
module sha256_msg_padder #(
  parameter int unsigned CNT_W = 61
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [0:511] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {FILL, EMIT_DATA, EMIT_PAD1, EMIT_PAD2} state_t;

  state_t           r_state, w_next;
  logic [0:511]     r_buf, w_fill_buf;
  logic [5:0]       r_cur;
  logic [6:0]       w_p;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             r_first_pending;
  logic             r_pad80;
  logic             w_in_fire;

  function automatic logic [63:0] len_of(input logic [CNT_W-1:0] c);
    len_of = '0;
    len_of[CNT_W+2:0] = {c, 3'b000};
  endfunction

  assign w_p       = {1'b0, r_cur} + 7'd1;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_in_fire = in_valid & in_ready;
  assign blk_data  = r_buf;

  // Bytes past the cursor are always zero here, so only the marker and the
  // length field need to be written when the final byte arrives.
  always_comb begin
    w_fill_buf = r_buf;
    w_fill_buf[{r_cur, 3'b000} +: 8] = in_data;
    if (in_last) begin
      if (w_p <= 7'd63)
        w_fill_buf[{w_p[5:0], 3'b000} +: 8] = 8'h80;
      if (w_p <= 7'd55)
        w_fill_buf[448 +: 64] = len_of(w_cnt_inc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    blk_first = 1'b0;
    blk_last  = 1'b0;
    case (r_state)
      FILL: begin
        in_ready = ~reset;
        if (in_valid) begin
          if (in_last)
            w_next = (w_p <= 7'd55) ? EMIT_PAD2 : EMIT_PAD1;
          else if (r_cur == 6'd63)
            w_next = EMIT_DATA;
        end
      end
      EMIT_DATA: begin
        blk_valid = 1'b1;
        blk_first = r_first_pending;
        if (blk_ready) w_next = FILL;
      end
      EMIT_PAD1: begin
        blk_valid = 1'b1;
        blk_first = r_first_pending;
        if (blk_ready) w_next = EMIT_PAD2;
      end
      EMIT_PAD2: begin
        blk_valid = 1'b1;
        blk_first = r_first_pending;
        blk_last  = 1'b1;
        if (blk_ready) w_next = FILL;
      end
      default: w_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf           <= '0;
      r_cur           <= '0;
      r_cnt           <= '0;
      r_first_pending <= 1'b1;
      r_pad80         <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_fire) begin
            r_buf   <= w_fill_buf;
            r_cur   <= r_cur + 6'd1;
            r_cnt   <= w_cnt_inc;
            r_pad80 <= in_last & w_p[6];
          end
        end
        EMIT_DATA: begin
          if (blk_ready) begin
            r_buf           <= '0;
            r_cur           <= '0;
            r_first_pending <= 1'b0;
          end
        end
        EMIT_PAD1: begin
          if (blk_ready) begin
            r_buf            <= '0;
            r_buf[0 +: 8]    <= r_pad80 ? 8'h80 : 8'h00;
            r_buf[448 +: 64] <= len_of(r_cnt);
            r_first_pending  <= 1'b0;
          end
        end
        EMIT_PAD2: begin
          if (blk_ready) begin
            r_buf           <= '0;
            r_cur           <= '0;
            r_cnt           <= '0;
            r_first_pending <= 1'b1;
            r_pad80         <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: stimulus pushes expected blocks,
// a negedge monitor pops and compares at each block handshake.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [0:511] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic         blk_first;
  logic         blk_last;

  typedef struct {
    logic [0:511] d;
    logic         f;
    logic         l;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   hs_count = 0;

  always #5 clk = ~clk;

  sha256_msg_padder #(.CNT_W(61)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake happens on the posedge following this sample point.
  always @(negedge clk) begin
    if (!reset && blk_valid && blk_ready) begin
      hs_count++;
      if (q.size() == 0) begin
        chk("unexpected_block", 512'(hs_count), 512'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("blk_data",  512'(blk_data),  512'(e.d));
        chk("blk_first", 512'(blk_first), 512'(e.f));
        chk("blk_last",  512'(blk_last),  512'(e.l));
      end
    end
  end

  task automatic push(input logic [0:511] d, input logic f, input logic l);
    exp_t e;
    e.d = d; e.f = f; e.l = l;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int guard;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    guard = 0;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("in_ready_timeout", 512'(guard), 512'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_abc();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((q.size() != 0 || blk_valid) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("drain_timeout", 512'(q.size()), 512'd0);
  endtask

  logic [0:511] abc_blk;
  logic [0:511] snap;
  string        msg15;
  int           hs0;
  int           guard;

  initial begin
    abc_blk  = {32'h61626380, 416'h0, 64'h18};
    msg15    = "projectfpga.com";
    reset    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  512'(in_ready),  512'd0);
    chk("rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("rst_blk_first", 512'(blk_first), 512'd0);
    chk("rst_blk_last",  512'(blk_last),  512'd0);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", 512'(in_ready), 512'd1);

    // "abc": single final block, valid one cycle after the last byte
    push(abc_blk, 1'b1, 1'b1);
    send_abc();
    @(negedge clk);
    chk("abc_latency_valid", 512'(blk_valid), 512'd1);
    wait_idle();

    // "projectfpga.com": 15 bytes, marker at byte 15, length 0x78
    push({120'h70726f6a656374667067612e636f6d, 8'h80, 320'h0, 64'h78}, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) send_byte(msg15[i], i == 14);
    wait_idle();

    // 56 bytes: marker spills into a non-final block, length-only block follows
    push({{56{8'h61}}, 8'h80, 56'h0}, 1'b1, 1'b0);
    push({448'h0, 64'h1C0}, 1'b0, 1'b1);
    for (int i = 0; i < 56; i++) send_byte(8'h61, i == 55);
    @(negedge clk);
    chk("b56_blk1_valid", 512'(blk_valid), 512'd1);
    chk("b56_blk1_last",  512'(blk_last),  512'd0);
    @(negedge clk);
    chk("b56_b2b_valid",  512'(blk_valid), 512'd1);
    chk("b56_b2b_last",   512'(blk_last),  512'd1);
    wait_idle();

    // 64 bytes: pure data block, then a block starting with the marker
    push(512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f,
         1'b1, 1'b0);
    push({8'h80, 440'h0, 64'h200}, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) send_byte(8'(i), i == 63);
    wait_idle();

    // Backpressure: block held stable and input stalled while blk_ready is low
    @(negedge clk);
    blk_ready = 1'b0;
    push(abc_blk, 1'b1, 1'b1);
    send_abc();
    hs0 = hs_count;
    guard = 0;
    @(negedge clk);
    while (!blk_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("bp_valid_seen", 512'(blk_valid), 512'd1);
    snap = blk_data;
    chk("bp_data_value", 512'(snap), 512'(abc_blk));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data_stable", 512'(blk_data),  512'(snap));
      chk("bp_valid_held",  512'(blk_valid), 512'd1);
      chk("bp_in_ready",    512'(in_ready),  512'd0);
    end
    blk_ready = 1'b1;
    @(negedge clk);
    chk("bp_one_handshake", 512'(hs_count - hs0), 512'd1);
    chk("bp_valid_drop",    512'(blk_valid),      512'd0);
    wait_idle();

    // Reset mid-stream discards the 20-byte partial message
    for (int i = 0; i < 20; i++) send_byte(8'h11, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("midrst_in_ready", 512'(in_ready), 512'd0);
    @(negedge clk);
    reset = 1'b0;
    push(abc_blk, 1'b1, 1'b1);
    send_abc();
    wait_idle();

    repeat (3) @(negedge clk);
    chk("block_count",  512'(hs_count), 512'd8);
    chk("queue_empty",  512'(q.size()), 512'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
